l1_infer: RTL and testbench
===========================

# l1_infer

Event-driven layer-1 inference engine for the digit-recognition SNN. It keeps per-channel decaying time-surface traces and consumes the weight and threshold buses produced by the layer-1 trainer. On each input event it computes every neuron's dot product against the traces and emits a one-hot winner spike plus all neuron sums. These drive the trainer's `i_lvl_spikeout` and `i_sv` ports.

## Interface
- `p_width`, 8, weight and trace width
- `p_shift`, 8, product headroom; must equal `p_width`
- `p_n`, 10, neuron count
- `p_s`, 25, input channels; `p_s` ≤ 32
- `p_spike_cycles`, 2, width of the winner spike in `i_clk` cycles
- `i_clk`  in  1  system clock
- `i_rst_n`  in  1  reset: asynchronous, active-low
- `i_syncout`  in  `[p_s:1]`  synchronous input events, one cycle per event; multi-hot allowed
- `i_trace_tick`  in  1  one-cycle decay strobe
- `i_weights`  in  `p_n*p_s*p_width`  weight bus; neuron j, channel i at bits `((j-1)*p_s+i)*p_width-1 : ((j-1)*p_s+i-1)*p_width`
- `i_thresholds`  in  `p_n*T`  threshold bus; T = `p_width+p_shift+5`; neuron j at bits `j*T-1 : (j-1)*T`
- `o_spikeout`  out  `[p_n:1]`  one-hot winner spike
- `o_sv`  out  `p_n*T`  per-neuron sums, same packing as `i_thresholds`
- `o_busy`  out  1  evaluation in progress
- `o_drop`  out  1  one-cycle pulse: an event arrived while busy

## Operation
- **Traces** `tr[1..p_s]`, `p_width` bits each, reset to 0. Each cycle, per channel:
  - if `i_syncout[i]`: load all-ones;
  - else if `i_trace_tick`: decrement by 1, saturating at 0.
  - Event beats tick on the same channel in the same cycle.
  - Traces update in every state, including while busy.
- **FSM states:** IDLE, LOAD, ACC, CMP, FIRE.
  - **IDLE:** `o_busy`=0. Any nonzero `i_syncout` → LOAD. Weights and thresholds are sampled live (they are not snapshotted).
  - **LOAD:** clear `acc[1..p_n]`; set channel index `k`=1 → ACC. This state also lets the triggering event's trace load settle.
  - **ACC:** one channel per cycle, all neurons in parallel: `acc[n] += w[n][k] * tr[k]`.
    - Product is `2*p_width` bits, zero-extended to T. Unsigned.
    - The sum cannot overflow: 25 × 255 × 255 < 2^21.
    - `k` runs 1..`p_s`; after `k`=`p_s` → CMP.
  - **CMP:** register `o_sv` ← `acc`.
    - Winner = neuron with the largest `acc[n]` among those with `acc[n] >= thr[n]`. On a tie, the lowest index wins.
    - No qualifier → IDLE, `o_spikeout` stays 0.
    - Otherwise → FIRE.
  - **FIRE:** drive the one-hot winner on `o_spikeout` for `p_spike_cycles` cycles, then → IDLE.
- **Busy events:** any `i_syncout` seen outside IDLE pulses `o_drop` the next cycle. The trace still updates, but no evaluation is queued.
- **Reset:** async assert clears traces, `acc`, `o_sv`, `o_spikeout`, `o_drop`, `o_busy`, and the state goes to IDLE. Reset mid-evaluation abandons that evaluation with no spike.

## Timing
- `o_busy`=1 from the cycle after the triggering event through the last FIRE cycle.
- Event at cycle 0 → LOAD at 1, ACC at 2..`p_s`+1, CMP at `p_s`+2, spike high at `p_s`+3..`p_s`+2+`p_spike_cycles`.
  - With defaults: spike high on cycles 28–29.
- ACC uses trace values registered at cycle 1. The triggering channel reads all-ones.
- `o_sv` is valid one cycle before the spike rises and holds until the next CMP. The trainer's spike-edge capture therefore sees stable sums.
- The first event accepted after returning to IDLE can start a new evaluation in the same cycle.
- The spike falls to 0 before IDLE; two spikes are always separated by ≥ `p_s`+3 low cycles.

## Structure
- Shared package (`snn_l1_pkg`):
  - `T` = `p_width+p_shift+5`
  - default widths
  - bus-slice index functions for the weight and threshold packing, shared with the trainer
- Sub-module `l1_argmax_thr`: combinational thresholded argmax over `p_n` sums, output one-hot plus a valid flag; used in CMP.
- The trace array and the FSM/accumulator stay in `l1_infer`.

## Test plan
- **Single event, no qualifier:** all weights 0xff, all thresholds 0x1ff00, event on ch 3 (traces otherwise 0). Required: `acc`=0xfe01 for all neurons, `o_sv` all 0xfe01, no spike, `o_busy` low at cycle 28.
- **Single event, winner:** thresholds 0xfe00, neuron 4 weight ch3=0xff, all other weights 0x80, event ch 3. Required: `o_spikeout`=0b0000001000 on cycles 28–29, `o_sv[4]`=0xfe01.
- **Tie:** neurons 2 and 7 have identical weights above threshold. Required: spike on neuron 2 only.
- **Decay and ordering:** event ch1, then 16 ticks, then event ch2, with tick and event coincident on ch2. Required: second evaluation uses tr1=0xef, tr2=0xff.
- **Busy drop:** second event 5 cycles into ACC. Required: `o_drop` pulse, no second spike, trace loaded to 0xff.
- **Reset mid-ACC:** assert `i_rst_n` low at cycle 10. Required: all outputs 0 immediately, IDLE, traces 0, no spike after release.

Source files
------------

// File: rtl/snn_l1_pkg.sv
// Shared constants and bus-packing helpers for the layer-1 SNN inference engine and trainer.
package snn_l1_pkg;
  localparam int P_WIDTH_DEF        = 8;
  localparam int P_SHIFT_DEF        = 8;
  localparam int P_N_DEF            = 10;
  localparam int P_S_DEF            = 25;
  localparam int P_SPIKE_CYCLES_DEF = 2;
  localparam int T_DEF              = P_WIDTH_DEF + P_SHIFT_DEF + 5;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_ACC, ST_CMP, ST_FIRE} l1_state_e;

  function automatic int sum_width(input int width, input int shift);
    return width + shift + 5;
  endfunction

  // LSB of neuron j, channel i (both 1-based) inside the packed weight bus.
  function automatic int weight_lsb(input int j, input int i, input int s, input int width);
    return ((j - 1) * s + i - 1) * width;
  endfunction

  function automatic int thr_lsb(input int j, input int t);
    return (j - 1) * t;
  endfunction
endpackage

// File: rtl/l1_argmax_thr.sv
// Combinational thresholded argmax: largest sum among neurons at or above threshold.
module l1_argmax_thr
  import snn_l1_pkg::*;
#(
  parameter int p_n = P_N_DEF,
  parameter int p_t = T_DEF
) (
  input  logic [p_n*p_t-1:0] sums_i,
  input  logic [p_n*p_t-1:0] thr_i,
  output logic [p_n:1]       onehot_o,
  output logic               valid_o
);
  logic [p_t-1:0] best;
  logic [p_t-1:0] sum_n;
  logic [p_t-1:0] thr_n;

  // Strict '>' on the running best keeps the lowest index on ties.
  always_comb begin
    onehot_o = '0;
    valid_o  = 1'b0;
    best     = '0;
    sum_n    = '0;
    thr_n    = '0;
    for (int n = 1; n <= p_n; n++) begin
      sum_n = sums_i[thr_lsb(n, p_t) +: p_t];
      thr_n = thr_i[thr_lsb(n, p_t) +: p_t];
      if (sum_n >= thr_n && (!valid_o || sum_n > best)) begin
        onehot_o    = '0;
        onehot_o[n] = 1'b1;
        valid_o     = 1'b1;
        best        = sum_n;
      end
    end
  end
endmodule

// File: rtl/l1_infer.sv
// Event-driven layer-1 inference: decaying per-channel traces, serial-channel dot products
// across all neurons in parallel, thresholded winner-take-all spike.
module l1_infer
  import snn_l1_pkg::*;
#(
  parameter int p_width        = P_WIDTH_DEF,
  parameter int p_shift        = P_SHIFT_DEF,
  parameter int p_n            = P_N_DEF,
  parameter int p_s            = P_S_DEF,
  parameter int p_spike_cycles = P_SPIKE_CYCLES_DEF,
  localparam int T             = p_width + p_shift + 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [p_s:1]               i_syncout,
  input  logic                       i_trace_tick,
  input  logic [p_n*p_s*p_width-1:0] i_weights,
  input  logic [p_n*T-1:0]           i_thresholds,
  output logic [p_n:1]               o_spikeout,
  output logic [p_n*T-1:0]           o_sv,
  output logic                       o_busy,
  output logic                       o_drop
);
  localparam int KW = $clog2(p_s + 1);
  localparam int FW = $clog2(p_spike_cycles + 1);
  localparam int PW = 2 * p_width;

  l1_state_e          state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [FW-1:0]      fire_q, fire_d;
  logic [p_n:1]       spike_q, spike_d;
  logic               drop_q;
  logic [p_width-1:0] tr_q   [1:p_s];
  logic [p_width-1:0] snap_q [1:p_s];
  logic [p_width-1:0] snap_sel;
  logic [p_n:1]       win_onehot;
  logic               win_valid;
  logic               last_k;
  logic               evt_any;

  assign evt_any = |i_syncout;
  assign last_k  = (k_q == KW'(p_s));

  // Traces run in every state; the snapshot freezes the values ACC will consume.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 1; i <= p_s; i++) begin
        tr_q[i]   <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i <= p_s; i++) begin
        if (i_syncout[i])
          tr_q[i] <= '1;
        else if (i_trace_tick && tr_q[i] != '0)
          tr_q[i] <= tr_q[i] - p_width'(1);
        if (state_q == ST_LOAD)
          snap_q[i] <= tr_q[i];
      end
    end
  end

  always_comb begin
    snap_sel = '0;
    for (int i = 1; i <= p_s; i++)
      if (k_q == KW'(i)) snap_sel = snap_q[i];
  end

  for (genvar gi = 1; gi <= p_n; gi++) begin : g_neuron
    logic [T-1:0]       acc_q;
    logic [T-1:0]       sv_q;
    logic [p_width-1:0] w_sel;
    logic [PW-1:0]      prod;
    logic [T-1:0]       acc_sum;

    always_comb begin
      w_sel = '0;
      for (int i = 1; i <= p_s; i++)
        if (k_q == KW'(i)) w_sel = i_weights[weight_lsb(gi, i, p_s, p_width) +: p_width];
    end

    assign prod    = PW'(w_sel) * PW'(snap_sel);
    assign acc_sum = acc_q + {{(T - PW){1'b0}}, prod};

    // The published sum is captured with the final product so it is visible during CMP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        acc_q <= '0;
        sv_q  <= '0;
      end else if (state_q == ST_LOAD) begin
        acc_q <= '0;
      end else if (state_q == ST_ACC) begin
        acc_q <= acc_sum;
        if (last_k) sv_q <= acc_sum;
      end
    end

    assign o_sv[thr_lsb(gi, T) +: T] = sv_q;
  end

  l1_argmax_thr #(
    .p_n (p_n),
    .p_t (T)
  ) u_argmax (
    .sums_i   (o_sv),
    .thr_i    (i_thresholds),
    .onehot_o (win_onehot),
    .valid_o  (win_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      fire_q  <= '0;
      spike_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      fire_q  <= fire_d;
      spike_q <= spike_d;
      drop_q  <= (state_q != ST_IDLE) && evt_any;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    fire_d  = fire_q;
    spike_d = spike_q;
    case (state_q)
      ST_IDLE: if (evt_any) state_d = ST_LOAD;
      ST_LOAD: begin
        k_d     = KW'(1);
        state_d = ST_ACC;
      end
      ST_ACC: begin
        if (last_k) state_d = ST_CMP;
        else        k_d     = k_q + KW'(1);
      end
      ST_CMP: begin
        if (win_valid) begin
          spike_d = win_onehot;
          fire_d  = FW'(1);
          state_d = ST_FIRE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FIRE: begin
        if (fire_q == FW'(p_spike_cycles)) begin
          spike_d = '0;
          state_d = ST_IDLE;
        end else begin
          fire_d = fire_q + FW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_spikeout = spike_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_drop     = drop_q;
endmodule

// File: tb/tb_l1_infer.sv
// Self-checking bench for l1_infer: directed cases from the test plan plus randomized traffic
// against a timestamp-based behavioural model.
module tb_l1_infer;
  localparam int P_W  = 8;
  localparam int P_SH = 8;
  localparam int P_N  = 10;
  localparam int P_S  = 25;
  localparam int P_SC = 2;
  localparam int T    = P_W + P_SH + 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [P_S:1] syncout = '0;
  logic tick = 1'b0;
  logic [7:0] wt [1:P_N][1:P_S];
  logic [T-1:0] thr [1:P_N];
  logic [P_N*P_S*P_W-1:0] weights_bus;
  logic [P_N*T-1:0] thr_bus;
  logic [P_N:1] spikeout;
  logic [P_N*T-1:0] sv;
  logic busy, drop;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  // Model state
  int tr_m [1:P_S];
  int sums_m [1:P_N];
  bit active;
  int t_m;
  bit win_m;
  int win_idx;
  int n_eval = 0;
  logic busy_e, drop_e;
  logic [P_N:1] spike_e;
  logic [P_N*T-1:0] sv_e;

  always #5 clk = ~clk;

  l1_infer #(
    .p_width(P_W), .p_shift(P_SH), .p_n(P_N), .p_s(P_S), .p_spike_cycles(P_SC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_syncout(syncout), .i_trace_tick(tick),
    .i_weights(weights_bus), .i_thresholds(thr_bus),
    .o_spikeout(spikeout), .o_sv(sv), .o_busy(busy), .o_drop(drop)
  );

  always_comb begin
    weights_bus = '0;
    thr_bus = '0;
    for (int n = 1; n <= P_N; n++) begin
      thr_bus[(n-1)*T +: T] = thr[n];
      for (int i = 1; i <= P_S; i++)
        weights_bus[((n-1)*P_S+i-1)*P_W +: P_W] = wt[n][i];
    end
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h, want %0h", name, $time, got, want);
    end
  endtask

  function automatic logic [P_S:1] ch(input int i);
    logic [P_S:1] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [T-1:0] sv_of(input int n);
    return sv[(n-1)*T +: T];
  endfunction

  task automatic fill(input logic [7:0] w, input logic [T-1:0] t);
    for (int n = 1; n <= P_N; n++) begin
      thr[n] = t;
      for (int i = 1; i <= P_S; i++) wt[n][i] = w;
    end
  endtask

  function automatic void model_reset();
    for (int i = 1; i <= P_S; i++) tr_m[i] = 0;
    active = 1'b0;
    t_m = 0;
    win_m = 1'b0;
    win_idx = 0;
    busy_e = 1'b0;
    drop_e = 1'b0;
    spike_e = '0;
    sv_e = '0;
  endfunction

  // Called once per rising edge with the inputs sampled there. t_m counts cycles since the
  // accepting edge: load at 1, sums published at p_s+2, spike over the following p_sc cycles.
  function automatic void model_edge(input logic [P_S:1] sync, input logic tk);
    bit start;
    int best;
    drop_e = busy_e && (sync != '0);
    start  = !busy_e && (sync != '0);
    for (int i = 1; i <= P_S; i++) begin
      if (sync[i]) tr_m[i] = 255;
      else if (tk && tr_m[i] > 0) tr_m[i] = tr_m[i] - 1;
    end
    if (start) begin
      active = 1'b1;
      t_m = 1;
      best = -1;
      for (int n = 1; n <= P_N; n++) begin
        sums_m[n] = 0;
        for (int i = 1; i <= P_S; i++) sums_m[n] += int'(wt[n][i]) * tr_m[i];
        if (sums_m[n] >= int'(thr[n]) && sums_m[n] > best) best = sums_m[n];
      end
      win_m = (best >= 0);
      win_idx = 0;
      for (int n = P_N; n >= 1; n--)
        if (win_m && sums_m[n] == best && sums_m[n] >= int'(thr[n])) win_idx = n;
      n_eval++;
      $display("eval %0d at t=%0t: winner=%0d best=%0h", n_eval, $time, win_idx, best);
    end else if (active) begin
      t_m++;
    end
    if (active && t_m > P_S + 2 + (win_m ? P_SC : 0)) active = 1'b0;
    busy_e = active;
    if (active && t_m == P_S + 2)
      for (int n = 1; n <= P_N; n++) sv_e[(n-1)*T +: T] = sums_m[n][T-1:0];
    spike_e = '0;
    if (active && win_m && t_m >= P_S + 3) spike_e[win_idx] = 1'b1;
  endfunction

  task automatic step(input logic [P_S:1] sync, input logic tk);
    @(negedge clk);
    syncout = sync;
    tick = tk;
    @(posedge clk);
    model_edge(sync, tk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_busy", busy, busy_e);
        check("cyc_drop", drop, drop_e);
        check("cyc_spike", spikeout, spike_e);
        check("cyc_sv", sv, sv_e);
      end
    end
  end

  initial begin
    int spk;
    fill(8'h00, '1);
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    #1;
    check("reset_busy", busy, 0);
    check("reset_spike", spikeout, 0);
    check("reset_sv", sv, 0);

    // 1: single event, nobody reaches threshold
    fill(8'hff, 21'h1ff00);
    step(ch(3), 1'b0);
    repeat (26) step('0, 1'b0);
    check("t1_busy27", busy, 1);
    for (int n = 1; n <= P_N; n++) check("t1_sv", sv_of(n), 21'hfe01);
    step('0, 1'b0);
    check("t1_busy28", busy, 0);
    check("t1_spike28", spikeout, 0);

    // 2: single winner on neuron 4
    fill(8'h80, 21'h0fe00);
    wt[4][3] = 8'hff;
    step(ch(3), 1'b0);
    repeat (27) step('0, 1'b0);
    check("t2_spike28", spikeout, 10'b0000001000);
    check("t2_sv4", sv_of(4), 21'hfe01);
    check("t2_sv1", sv_of(1), 21'h7f80);
    step('0, 1'b0);
    check("t2_spike29", spikeout, 10'b0000001000);
    step('0, 1'b0);
    check("t2_spike30", spikeout, 0);
    check("t2_busy30", busy, 0);

    // 3: tie between neurons 2 and 7
    fill(8'h80, 21'h0fe00);
    wt[2][3] = 8'hff;
    wt[7][3] = 8'hff;
    step(ch(3), 1'b0);
    repeat (27) step('0, 1'b0);
    check("t3_spike", spikeout, 10'b0000000010);
    check("t3_sv7", sv_of(7), 21'hfe01);
    repeat (2) step('0, 1'b0);

    // 4: decay and event-over-tick priority
    fill(8'h00, '1);
    wt[1][1] = 8'h01;
    wt[2][2] = 8'h01;
    step(ch(1), 1'b0);
    repeat (27) step('0, 1'b0);
    repeat (15) step('0, 1'b1);
    step(ch(2), 1'b1);
    repeat (27) step('0, 1'b0);
    check("t4_tr1", sv_of(1), 21'h0000ef);
    check("t4_tr2", sv_of(2), 21'h0000ff);

    // 5: event during ACC is dropped but still loads its trace
    fill(8'h00, '0);
    wt[1][1] = 8'h01;
    step(ch(1), 1'b0);
    repeat (6) step('0, 1'b0);
    step(ch(5), 1'b0);
    check("t5_drop", drop, 1);
    spk = 0;
    repeat (60) begin
      step('0, 1'b0);
      if (spikeout != '0) spk++;
    end
    check("t5_spike_cycles", spk, 2);
    fill(8'h00, '1);
    wt[2][5] = 8'h01;
    step(ch(1), 1'b0);
    repeat (27) step('0, 1'b0);
    check("t5_tr5", sv_of(2), 21'h0000ff);

    // 6: reset in the middle of ACC
    fill(8'h00, '0);
    wt[1][1] = 8'h01;
    step(ch(1), 1'b0);
    repeat (9) step('0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_busy", busy, 0);
    check("t6_spike", spikeout, 0);
    check("t6_sv", sv, 0);
    check("t6_drop", drop, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spk = 0;
    repeat (40) begin
      step('0, 1'b0);
      if (spikeout != '0) spk++;
    end
    check("t6_no_spike", spk, 0);
    fill(8'h00, '1);
    wt[1][5] = 8'h01;
    wt[2][1] = 8'h01;
    step(ch(1), 1'b0);
    repeat (27) step('0, 1'b0);
    check("t6_tr5_cleared", sv_of(1), 0);
    check("t6_tr1", sv_of(2), 21'h0000ff);

    // Randomized traffic; weights only change while the model is idle.
    for (int c = 0; c < 4000; c++) begin
      logic [P_S:1] m;
      m = '0;
      if (!busy_e && $urandom_range(0, 15) == 0) begin
        for (int n = 1; n <= P_N; n++) begin
          thr[n] = T'($urandom_range(0, 21'h180000));
          for (int i = 1; i <= P_S; i++) wt[n][i] = 8'($urandom_range(0, 255));
        end
      end
      if ($urandom_range(0, 5) == 0)
        repeat ($urandom_range(1, 3)) m[$urandom_range(1, P_S)] = 1'b1;
      step(m, $urandom_range(0, 2) == 0);
    end
    step('0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
